// File: rtl/register_addr_bank.sv
// register_addr_bank
//
// A bank of COUNT address registers, such as the program counter, stack
// pointer and index pointers. One register, chosen by wr_sel, can change on
// each rising clock edge. The first matching operation in this list wins:
//   - it loads from the transfer bus (load_xfer);
//   - it loads its low and/or high byte from the data bus (load_lo/load_hi);
//   - it steps up or down by 1..4 (inc/dec).
// The wrap flag records the carry or borrow of the last step. Two
// combinational read ports drive the address bus and the transfer bus.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; clears registers and wrap
//   xfer_in      transfer bus input (WIDTH bits)
//   data_in      data bus byte input
//   wr_sel       register targeted by load/inc/dec
//   load_xfer    load target from xfer_in
//   load_lo      load data_in into target bits [7:0]
//   load_hi      load data_in into target bits [WIDTH-1:WIDTH-8]
//   inc, dec     step target up/down by step+1 (both together: no-op)
//   step         step amount minus one
//   addr_sel     register shown on addr_out; assert_addr enables it
//   addr_out     reg[addr_sel] or 0
//   xfer_sel     register shown on xfer_out; assert_xfer enables it
//   xfer_out     reg[xfer_sel] or 0
//   wrap         registered carry/borrow of the last inc/dec
//   wr_zero      reg[wr_sel] == 0 (combinational)
module register_addr_bank #(
    parameter int WIDTH = 16,
    parameter int COUNT = 4,
    localparam int SEL_W = $clog2(COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  xfer_in,
    input  logic [7:0]        data_in,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic              load_xfer,
    input  logic              load_lo,
    input  logic              load_hi,
    input  logic              inc,
    input  logic              dec,
    input  logic [1:0]        step,
    input  logic [SEL_W-1:0]  addr_sel,
    input  logic              assert_addr,
    output logic [WIDTH-1:0]  addr_out,
    input  logic [SEL_W-1:0]  xfer_sel,
    input  logic              assert_xfer,
    output logic [WIDTH-1:0]  xfer_out,
    output logic              wrap,
    output logic              wr_zero
);

    logic [WIDTH-1:0] regs_q [COUNT];
    logic [WIDTH-1:0] regs_d [COUNT];
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH-1:0] wr_cur;
    logic [WIDTH-1:0] wr_new;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   step_sum;
    logic             wr_hit;

    // Next-state logic for the single register addressed by wr_sel.
    always_comb begin
        regs_d   = regs_q;
        wrap_d   = wrap_q;
        wr_cur   = '0;
        wr_hit   = 1'b0;
        step_sum = '0;
        step_ext = (WIDTH+1)'(step) + (WIDTH+1)'(1);

        for (int i = 0; i < COUNT; i++) begin
            if (wr_sel == SEL_W'(i)) begin
                wr_cur = regs_q[i];
                wr_hit = 1'b1;
            end
        end

        wr_new = wr_cur;
        if (load_xfer) begin
            wr_new = xfer_in;
            wrap_d = 1'b0;
        end else if (load_lo || load_hi) begin
            // Byte loads only touch the end bytes; middle bytes keep their value.
            if (load_lo) wr_new[7:0] = data_in;
            if (load_hi) wr_new[WIDTH-1 -: 8] = data_in;
            wrap_d = 1'b0;
        end else if (inc && !dec) begin
            // The extra top bit of the sum is the carry out.
            step_sum = {1'b0, wr_cur} + step_ext;
            wr_new   = step_sum[WIDTH-1:0];
            wrap_d   = step_sum[WIDTH];
        end else if (dec && !inc) begin
            // The top bit goes to 1 when the subtraction borrows.
            step_sum = {1'b0, wr_cur} - step_ext;
            wr_new   = step_sum[WIDTH-1:0];
            wrap_d   = step_sum[WIDTH];
        end

        // A select that names no register (COUNT not a power of two) is inert.
        if (!wr_hit) begin
            wrap_d = wrap_q;
        end

        for (int i = 0; i < COUNT; i++) begin
            if (wr_hit && wr_sel == SEL_W'(i)) begin
                regs_d[i] = wr_new;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
            wrap_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            wrap_q <= wrap_d;
        end
    end

    // Read ports show the pre-edge state. Unused selects drive 0.
    always_comb begin
        addr_out = '0;
        xfer_out = '0;
        wr_zero  = 1'b1;
        for (int i = 0; i < COUNT; i++) begin
            if (assert_addr && addr_sel == SEL_W'(i)) addr_out = regs_q[i];
            if (assert_xfer && xfer_sel == SEL_W'(i)) xfer_out = regs_q[i];
            if (wr_sel == SEL_W'(i)) wr_zero = (regs_q[i] == '0);
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_register_addr_bank.sv
// Bench for register_addr_bank. It drives two instances from one stimulus
// stream: the default 16-bit x 4 bank and a 24-bit x 3 bank.
module tb_register_addr_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] xfer_in;
    logic [7:0]  data_in;
    logic [1:0]  wr_sel, addr_sel, xfer_sel, step;
    logic        load_xfer, load_lo, load_hi, inc, dec, assert_addr, assert_xfer;

    logic [15:0] a_addr, a_xfer;
    logic        a_wrap, a_wz;
    logic [23:0] b_addr, b_xfer;
    logic        b_wrap, b_wz;

    int total = 0;
    int bad = 0;

    // Model state: register contents as plain integers
    longint ma [4];
    longint mb [4];
    bit     wa, wb;

    always #5 clk = ~clk;

    register_addr_bank #(.WIDTH(16), .COUNT(4)) dut_a (
        .clk(clk), .reset(reset), .xfer_in(xfer_in[15:0]), .data_in(data_in),
        .wr_sel(wr_sel), .load_xfer(load_xfer), .load_lo(load_lo), .load_hi(load_hi),
        .inc(inc), .dec(dec), .step(step),
        .addr_sel(addr_sel), .assert_addr(assert_addr), .addr_out(a_addr),
        .xfer_sel(xfer_sel), .assert_xfer(assert_xfer), .xfer_out(a_xfer),
        .wrap(a_wrap), .wr_zero(a_wz)
    );

    register_addr_bank #(.WIDTH(24), .COUNT(3)) dut_b (
        .clk(clk), .reset(reset), .xfer_in(xfer_in), .data_in(data_in),
        .wr_sel(wr_sel), .load_xfer(load_xfer), .load_lo(load_lo), .load_hi(load_hi),
        .inc(inc), .dec(dec), .step(step),
        .addr_sel(addr_sel), .assert_addr(assert_addr), .addr_out(b_addr),
        .xfer_sel(xfer_sel), .assert_xfer(assert_xfer), .xfer_out(b_xfer),
        .wrap(b_wrap), .wr_zero(b_wz)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compute the register value and wrap flag after one edge, using the
    // arithmetic rules for a W-bit register.
    function automatic void next_state(input int w, input longint cur, input bit wcur,
                                       output longint nv, output bit nw);
        longint modv;
        longint full;
        modv = longint'(1) << w;
        nv = cur;
        nw = wcur;
        if (load_xfer) begin
            nv = longint'(xfer_in) % modv;
            nw = 1'b0;
        end else if (load_lo || load_hi) begin
            if (load_lo) nv = (nv / 256) * 256 + longint'(data_in);
            if (load_hi) nv = (nv % (modv / 256)) + longint'(data_in) * (modv / 256);
            nw = 1'b0;
        end else if (inc && !dec) begin
            full = cur + longint'(step) + 1;
            nw = (full >= modv);
            nv = full % modv;
        end else if (dec && !inc) begin
            full = cur - longint'(step) - 1;
            nw = (full < 0);
            nv = (full < 0) ? full + modv : full;
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        longint nv;
        bit     nw;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                ma[i] = 0;
                mb[i] = 0;
            end
            wa = 1'b0;
            wb = 1'b0;
        end else begin
            next_state(16, ma[wr_sel], wa, nv, nw);
            ma[wr_sel] = nv;
            wa = nw;
            if (wr_sel < 3) begin
                next_state(24, mb[wr_sel], wb, nv, nw);
                mb[wr_sel] = nv;
                wb = nw;
            end
        end
    end

    // Check every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        chk("a_addr", 32'(a_addr), assert_addr ? 32'(ma[addr_sel]) : 32'd0);
        chk("a_xfer", 32'(a_xfer), assert_xfer ? 32'(ma[xfer_sel]) : 32'd0);
        chk("a_wrap", 32'(a_wrap), 32'(wa));
        chk("a_wz",   32'(a_wz),   32'(ma[wr_sel] == 0));
        chk("b_addr", 32'(b_addr), (assert_addr && addr_sel < 3) ? 32'(mb[addr_sel]) : 32'd0);
        chk("b_xfer", 32'(b_xfer), (assert_xfer && xfer_sel < 3) ? 32'(mb[xfer_sel]) : 32'd0);
        chk("b_wrap", 32'(b_wrap), 32'(wb));
        chk("b_wz",   32'(b_wz),   (wr_sel < 3) ? 32'(mb[wr_sel] == 0) : 32'd1);
    end

    task automatic op(input logic [1:0] sel, input logic lx, input logic [23:0] xv,
                      input logic ll, input logic lh, input logic [7:0] d,
                      input logic i, input logic dd, input logic [1:0] st);
        wr_sel = sel; load_xfer = lx; xfer_in = xv; load_lo = ll; load_hi = lh;
        data_in = d; inc = i; dec = dd; step = st;
        @(posedge clk); #2;
        load_xfer = 1'b0; load_lo = 1'b0; load_hi = 1'b0; inc = 1'b0; dec = 1'b0;
    endtask

    task automatic ldx(input logic [1:0] sel, input logic [23:0] v);
        op(sel, 1'b1, v, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic rd_a(input string name, input logic [1:0] sel, input logic [31:0] exp);
        addr_sel = sel; assert_addr = 1'b1; #1;
        chk(name, 32'(a_addr), exp);
    endtask

    task automatic rd_b(input string name, input logic [1:0] sel, input logic [31:0] exp);
        xfer_sel = sel; assert_xfer = 1'b1; #1;
        chk(name, 32'(b_xfer), exp);
    endtask

    initial begin
        xfer_in = '0; data_in = '0; wr_sel = '0; addr_sel = '0; xfer_sel = '0; step = '0;
        load_xfer = 0; load_lo = 0; load_hi = 0; inc = 0; dec = 0;
        assert_addr = 0; assert_xfer = 0;

        // Reset state
        repeat (2) begin @(posedge clk); #2; end
        rd_a("rst_addr", 2'd0, 32'h0);
        chk("rst_wrap", 32'(a_wrap), 32'h0);
        chk("rst_wz", 32'(a_wz), 32'h1);
        reset = 1'b1;

        // Preload, set wrap, then assert reset mid-cycle
        ldx(2'd0, 24'h001234);
        rd_a("preload", 2'd0, 32'h1234);
        ldx(2'd1, 24'hFFFFFF);
        op(2'd1, 0, 24'h0, 0, 0, 8'h0, 1, 0, 2'd0);
        chk("pre_wrap", 32'(a_wrap), 32'h1);
        reset = 1'b0;
        rd_a("async_addr", 2'd0, 32'h0);
        chk("async_wrap_a", 32'(a_wrap), 32'h0);
        chk("async_wrap_b", 32'(b_wrap), 32'h0);

        // Hold inc across the release; it applies once
        wr_sel = 2'd0; inc = 1'b1; step = 2'd0;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        inc = 1'b0;
        rd_a("inc_release", 2'd0, 32'h0001);

        // Loads on reg2
        ldx(2'd2, 24'hC0BEEF);
        rd_a("ld_xfer", 2'd2, 32'hBEEF);
        op(2'd2, 0, 24'h0, 1, 0, 8'h12, 0, 0, 2'd0);
        rd_a("ld_lo", 2'd2, 32'hBE12);
        op(2'd2, 0, 24'h0, 0, 1, 8'h34, 0, 0, 2'd0);
        rd_a("ld_hi", 2'd2, 32'h3412);
        op(2'd2, 0, 24'h0, 1, 1, 8'hAA, 0, 0, 2'd0);
        rd_a("ld_both", 2'd2, 32'hAAAA);
        chk("ld_both_wrap", 32'(a_wrap), 32'h0);
        rd_b("ld_both_b", 2'd2, 32'hAABEAA);

        // Step sizes and wrap on reg1
        ldx(2'd1, 24'hFFFFFE);
        op(2'd1, 0, 24'h0, 0, 0, 8'h0, 1, 0, 2'd3);
        rd_a("inc4", 2'd1, 32'h0002);
        chk("inc4_wrap", 32'(a_wrap), 32'h1);
        chk("inc4_wrap_b", 32'(b_wrap), 32'h1);
        op(2'd1, 0, 24'h0, 0, 0, 8'h0, 1, 0, 2'd0);
        rd_a("inc1", 2'd1, 32'h0003);
        chk("inc1_wrap", 32'(a_wrap), 32'h0);
        op(2'd1, 0, 24'h0, 0, 0, 8'h0, 0, 1, 2'd3);
        rd_a("dec4", 2'd1, 32'hFFFF);
        chk("dec4_wrap", 32'(a_wrap), 32'h1);
        rd_b("dec4_b", 2'd1, 32'hFFFFFF);

        // inc and dec together leave the register and wrap alone
        op(2'd1, 0, 24'h0, 0, 0, 8'h0, 1, 1, 2'd2);
        rd_a("incdec", 2'd1, 32'hFFFF);
        chk("incdec_wrap", 32'(a_wrap), 32'h1);

        // Priority on reg3; sel 3 does not exist in the 3-register bank
        ldx(2'd3, 24'h000010);
        rd_a("prio_pre", 2'd3, 32'h0010);
        op(2'd3, 1, 24'h000500, 1, 0, 8'h77, 1, 0, 2'd1);
        rd_a("prio", 2'd3, 32'h0500);
        chk("prio_wrap", 32'(a_wrap), 32'h0);
        chk("bad_sel_wrap_b", 32'(b_wrap), 32'h1);
        op(2'd3, 0, 24'h0, 0, 0, 8'h0, 1, 0, 2'd0);
        rd_b("bad_sel_r0", 2'd0, 32'h000001);
        rd_b("bad_sel_r1", 2'd1, 32'hFFFFFF);
        rd_b("bad_sel_r2", 2'd2, 32'hAABEAA);
        rd_a("inc_r3", 2'd3, 32'h0501);

        // Dual read and pre-edge visibility
        ldx(2'd0, 24'h001000);
        ldx(2'd1, 24'h002000);
        addr_sel = 2'd0; xfer_sel = 2'd1; assert_addr = 1'b1; assert_xfer = 1'b1; #1;
        chk("dual_addr", 32'(a_addr), 32'h1000);
        chk("dual_xfer", 32'(a_xfer), 32'h2000);
        assert_addr = 1'b0; #1;
        chk("deassert", 32'(a_addr), 32'h0);
        assert_addr = 1'b1;
        wr_sel = 2'd0; inc = 1'b1; step = 2'd0; #1;
        chk("pre_edge", 32'(a_addr), 32'h1000);
        @(posedge clk); #2;
        inc = 1'b0;
        chk("post_edge", 32'(a_addr), 32'h1001);

        // High byte load in the 24-bit bank keeps the middle byte
        op(2'd0, 0, 24'h0, 0, 1, 8'h7F, 0, 0, 2'd0);
        rd_b("hi_24", 2'd0, 32'h7F1001);
        rd_a("hi_16", 2'd0, 32'h7F01);
        chk("wz_nonzero_b", 32'(b_wz), 32'h0);
        ldx(2'd0, 24'h000000);
        #1;
        chk("wz_zero_a", 32'(a_wz), 32'h1);
        chk("wz_zero_b", 32'(b_wz), 32'h1);

        // Read select beyond COUNT drives 0
        rd_a("sel3_a", 2'd3, 32'h0501);
        chk("sel3_b", 32'(b_addr), 32'h0);

        @(posedge clk); #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_addr_bank.md
# register_addr_bank

Parametrised bank of COUNT address registers (program counter, stack pointer, index and scratch pointers) that replaces single-register address holders in the CPU datapath. Each register loads from the transfer bus or byte-wise from the 8-bit data bus, and can be stepped up or down by 1–4 with a wrap flag. Two independent read ports drive the address bus and the transfer bus. All updates are single-cycle on the rising clock edge.

## Interface
Parameters:
- WIDTH, 16, register width in bits; must be a multiple of 8 and at least 16
- COUNT, 4, number of registers; must be at least 2; SEL_W = $clog2(COUNT) is derived, not overridable

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- xfer_in  in  WIDTH  transfer bus input
- data_in  in  8  data bus byte input
- wr_sel  in  SEL_W  target register for load/inc/dec
- load_xfer  in  1  load target from xfer_in
- load_lo  in  1  load data_in into target bits [7:0]
- load_hi  in  1  load data_in into target bits [WIDTH-1:WIDTH-8]
- inc  in  1  add (step+1) to target
- dec  in  1  subtract (step+1) from target
- step  in  2  step amount minus one (0..3 selects 1..4)
- addr_sel  in  SEL_W  register driven on addr_out
- assert_addr  in  1  enable addr_out
- addr_out  out  WIDTH  reg[addr_sel] when assert_addr=1, else 0
- xfer_sel  in  SEL_W  register driven on xfer_out
- assert_xfer  in  1  enable xfer_out
- xfer_out  out  WIDTH  reg[xfer_sel] when assert_xfer=1, else 0
- wrap  out  1  registered; 1 when the last inc/dec wrapped modulo 2^WIDTH
- wr_zero  out  1  combinational; 1 when reg[wr_sel]==0

## Operation
- Exactly one register (wr_sel) can be modified per cycle. Priority, highest first: load_xfer > (load_lo/load_hi) > inc/dec.
- load_xfer: reg <= xfer_in. Any load_lo/load_hi/inc/dec asserted in the same cycle is ignored.
- load_lo and load_hi are independent. Both asserted: data_in is written to both bytes, and middle bytes (WIDTH>16) are unchanged. Either load suppresses inc/dec.
- inc and dec both asserted, with no load: register unchanged, wrap unchanged (no-op).
- inc alone: reg <= (reg + step + 1) mod 2^WIDTH. wrap <= carry out.
- dec alone: reg <= (reg - step - 1) mod 2^WIDTH. wrap <= borrow.
- Any load clears wrap to 0. Idle cycles hold wrap.
- wr_sel >= COUNT (non-power-of-two COUNT): all writes are ignored and wrap holds. Read selects >= COUNT drive 0.
- Read ports are combinational from current register state and show pre-edge values. Write-to-read forwarding is not provided.
- addr_sel and xfer_sel may equal each other and wr_sel. Both ports then drive the same value.

## Timing
- Reset asserted (reset=0): all registers, wrap, addr_out and xfer_out go to 0 immediately, independent of clk. wr_zero=1.
- Reset dominates all controls. An operation pending when reset asserts is discarded, not deferred.
- First edge after reset deasserts: normal operation. An inc held high across the release applies once on that edge.
- Write latency is 1 cycle: the value is visible on read ports and wr_zero after the rising edge.
- Read latency is 0 cycles: combinational from sel/assert inputs.
- wrap updates on the same edge as the register it describes.
- No handshake. Controls are sampled every edge and must be stable around the edge.

## Test plan
- Reset: preload reg0=16'h1234, pull reset low mid-cycle -> addr_out=0 and wrap=0 before the next edge. Release, assert inc on wr_sel=0 -> reg0=16'h0001 after one edge.
- Loads: load_xfer 16'hBEEF into reg2, then load_lo data_in=8'h12 -> 16'hBE12. Then load_hi data_in=8'h34 -> 16'h3412. load_lo+load_hi with 8'hAA -> 16'hAAAA, wrap=0.
- Step/wrap: reg1=16'hFFFE, inc with step=3 -> 16'h0002, wrap=1. inc step=0 -> 16'h0003, wrap=0. dec step=3 -> 16'hFFFF, wrap=1.
- Priority: reg3=16'h0010 with load_xfer=16'h0500 + inc + load_lo in the same cycle -> 16'h0500. inc+dec together -> unchanged, wrap held.
- Dual read: reg0=16'h1000, reg1=16'h2000; addr_sel=0, xfer_sel=1, both asserted -> addr_out=16'h1000, xfer_out=16'h2000. Deassert assert_addr -> addr_out=0. Same-cycle inc on reg0 -> addr_out shows 16'h1000 until the edge, then 16'h1001.
- Parametrisation: WIDTH=24, COUNT=3. load_hi 8'h7F -> bits[23:16]=7F, middle byte unchanged. wr_sel=3 with inc -> no register changes. wr_zero tracks reg[wr_sel].
